// File: rtl/decryption_keybank.sv
// Decryption key register file: software-written shadow bank, copied atomically to the active bank
// on COMMIT once the datapath is idle. Define DECRYPTION_KEYBANK_LOCK_EN to build the sticky write lock.
module decryption_keybank #(
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter int unsigned           REG_WIDTH    = 16,
  parameter int unsigned           N_KEYS       = 3,
  parameter logic [ADDR_WIDTH-1:0] KEY_BASE     = ADDR_WIDTH'('h10),
  parameter int unsigned           SELECT_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic                        read,
  input  logic                        write,
  input  logic [REG_WIDTH-1:0]        wdata,
  output logic [REG_WIDTH-1:0]        rdata,
  output logic                        done,
  output logic                        error,
  input  logic                        busy,
  output logic [REG_WIDTH-1:0]        select,
  output logic [N_KEYS*REG_WIDTH-1:0] keys,
  output logic                        pending,
  output logic                        cfg_update
);

  localparam logic [ADDR_WIDTH-1:0] A_SELECT = '0;
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(4);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                  state, state_nx;
  logic                    commit_now;
  logic [SELECT_WIDTH-1:0] sel_sh, sel_act;
  logic [REG_WIDTH-1:0]    key_sh  [N_KEYS];
  logic [REG_WIDTH-1:0]    key_act [N_KEYS];
  logic [N_KEYS-1:0]       key_sel, wr_key;
  logic [REG_WIDTH-1:0]    key_rd, rd_val;
  logic                    access, acc_err, frozen, wr_sel, wr_commit;
  logic                    locked;

  function automatic logic [REG_WIDTH-1:0] key_rst(input int unsigned i);
    case (i)
      1:       return '1;
      2:       return REG_WIDTH'(2);
      default: return '0;
    endcase
  endfunction

`ifdef DECRYPTION_KEYBANK_LOCK_EN
  logic wr_lock;

  always_ff @(posedge clk) begin
    if (rst)          locked <= 1'b0;
    else if (wr_lock) locked <= 1'b1;
  end
`else
  assign locked = 1'b0;
`endif

  assign access  = read | write;
  assign pending = (state == ST_WAIT);
  assign frozen  = (state == ST_WAIT) || locked;

  always_comb begin
    key_sel = '0;
    key_rd  = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      key_sel[i] = (addr == KEY_BASE + ADDR_WIDTH'(2 * i));
      key_rd     = key_rd | (key_sh[i] & {REG_WIDTH{key_sel[i]}});
    end
  end

  // Write-enable flags are only raised on error-free write paths, so they need no further gating.
  always_comb begin
    acc_err   = 1'b0;
    rd_val    = '0;
    wr_sel    = 1'b0;
    wr_key    = '0;
    wr_commit = 1'b0;
`ifdef DECRYPTION_KEYBANK_LOCK_EN
    wr_lock   = 1'b0;
`endif
    if (read && write) begin
      acc_err = 1'b1;
    end else if (addr == A_SELECT) begin
      if (!write)      rd_val = REG_WIDTH'(sel_sh);
      else if (frozen) acc_err = 1'b1;
      else             wr_sel = 1'b1;
    end else if (addr == A_CTRL) begin
      if (!write) begin
        rd_val = REG_WIDTH'({locked, 1'b0});
      end else if (locked && wdata[1]) begin
        acc_err = 1'b1;
      end else begin
        wr_commit = wdata[0];
`ifdef DECRYPTION_KEYBANK_LOCK_EN
        wr_lock   = wdata[1];
`endif
      end
    end else if (addr == A_STATUS) begin
      if (!write) rd_val = REG_WIDTH'({locked, busy, pending});
      else        acc_err = 1'b1;
    end else if (|key_sel) begin
      if (!write)      rd_val = key_rd;
      else if (frozen) acc_err = 1'b1;
      else             wr_key = key_sel;
    end else begin
      acc_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    commit_now = 1'b0;
    case (state)
      ST_IDLE: if (wr_commit) state_nx = ST_WAIT;
      ST_WAIT: if (!busy) begin
        state_nx   = ST_IDLE;
        commit_now = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_sh     <= '0;
      sel_act    <= '0;
      rdata      <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cfg_update <= 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        key_sh[i]  <= key_rst(i);
        key_act[i] <= key_rst(i);
      end
    end else begin
      done       <= access;
      error      <= access && acc_err;
      rdata      <= (read && !write && !acc_err) ? rd_val : '0;
      cfg_update <= commit_now;
      if (wr_sel) sel_sh <= wdata[SELECT_WIDTH-1:0];
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (wr_key[i])  key_sh[i]  <= wdata;
        if (commit_now) key_act[i] <= key_sh[i];
      end
      if (commit_now) sel_act <= sel_sh;
    end
  end

  assign select = REG_WIDTH'(sel_act);

  always_comb begin
    keys = '0;
    for (int unsigned i = 0; i < N_KEYS; i++)
      keys[i*REG_WIDTH +: REG_WIDTH] = key_act[i];
  end

endmodule
